// File: rtl/tpu_pkg.sv
// Shared types and the accumulate helper for the systolic array and its PEs.
package tpu_pkg;

  // Default widths; modules carry their own parameters and size locally.
  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;
  localparam int ROW_W       = $clog2(DEF_DIM);

  typedef logic signed [DEF_BITS_AB-1:0] ab_t;
  typedef logic signed [DEF_BITS_C-1:0]  c_t;

  // Wide working type so one helper serves any accumulator width up to 62 bits.
  typedef logic signed [63:0] wide_t;

  // Adds a sign-extended product to an accumulator. With sat set the sum is
  // clamped to the signed range of 'bits'; otherwise the caller truncates.
  function automatic wide_t sat_add(input wide_t acc, input wide_t product,
                                    input int unsigned bits, input bit sat);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = acc + product;
    hi  = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    if (sat && (sum > hi)) begin
      sum = hi;
    end else if (sat && (sum < lo)) begin
      sum = lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/tpu_systolic_array_pe.sv
// One multiply-accumulate processing element: forwards its operands to the
// right/down neighbours and accumulates their product.
module tpu_pe
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int SAT     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      ld,
  input  logic signed [BITS_AB-1:0] ain,
  input  logic signed [BITS_AB-1:0] bin,
  input  logic signed [BITS_C-1:0]  cld,
  output logic signed [BITS_AB-1:0] aout,
  output logic signed [BITS_AB-1:0] bout,
  output logic signed [BITS_C-1:0]  acc
);

  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    next_acc;

  // Product and wrapped/clamped next accumulator value.
  always_comb begin
    prod     = ain * bin;
    next_acc = BITS_C'(sat_add(wide_t'(acc), wide_t'(prod), BITS_C, SAT != 0));
  end

  // Operand shift on en; a row load overrides the MAC but not the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      aout <= '0;
      bout <= '0;
      acc  <= '0;
    end else begin
      if (en) begin
        aout <= ain;
        bout <= bin;
      end
      if (ld) begin
        acc <= cld;
      end else if (en) begin
        acc <= next_acc;
      end
    end
  end

endmodule

// File: rtl/tpu_systolic_array.sv
// DIM x DIM output-stationary systolic array computing C = A x B. Row i of A
// enters at column 0, column j of B enters at row 0, both optionally skewed
// internally so PE(i,j) meets A(i,k) and B(k,j) on en-cycle k+i+j.
module tpu_systolic_array
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int SAT     = 0,
  parameter int SKEW    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          WrEn,
  input  logic [$clog2(DIM)-1:0]        Crow,
  input  logic [DIM-1:0][BITS_AB-1:0]   A,
  input  logic [DIM-1:0][BITS_AB-1:0]   B,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic [DIM-1:0][BITS_C-1:0]    Cout
);

  localparam int ROW_BITS = $clog2(DIM);

  if (BITS_C < 2 * BITS_AB) begin : g_bad_bits_c
    $error("tpu_systolic_array: BITS_C must be >= 2*BITS_AB");
  end
  if (BITS_C > 62) begin : g_bad_bits_wide
    $error("tpu_systolic_array: BITS_C must be <= 62");
  end
  if (DIM < 2) begin : g_bad_dim
    $error("tpu_systolic_array: DIM must be >= 2");
  end

  logic [BITS_AB-1:0] a_edge [DIM];
  logic [BITS_AB-1:0] b_edge [DIM];
  logic [BITS_AB-1:0] a_pipe [DIM][DIM];
  logic [BITS_AB-1:0] b_pipe [DIM][DIM];
  logic [BITS_C-1:0]  acc    [DIM][DIM];
  logic               unused_edges;

  // Diagonal delay lines: row i of A and column j of B get i / j registers.
  for (genvar i = 0; i < DIM; i++) begin : g_skew
    if (SKEW != 0 && i > 0) begin : g_dly
      logic [BITS_AB-1:0] a_sr [i];
      logic [BITS_AB-1:0] b_sr [i];

      // Shift the skew registers only when the array advances.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < i; k++) begin
            a_sr[k] <= '0;
            b_sr[k] <= '0;
          end
        end else if (en) begin
          a_sr[0] <= A[i];
          b_sr[0] <= B[i];
          for (int k = 1; k < i; k++) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
          end
        end
      end

      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end else begin : g_direct
      assign a_edge[i] = A[i];
      assign b_edge[i] = B[i];
    end
  end

  // PE grid: operands flow right along rows and down along columns.
  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      logic [BITS_AB-1:0] ain_w;
      logic [BITS_AB-1:0] bin_w;

      if (j == 0) begin : g_ain_edge
        assign ain_w = a_edge[i];
      end else begin : g_ain_pipe
        assign ain_w = a_pipe[i][j-1];
      end

      if (i == 0) begin : g_bin_edge
        assign bin_w = b_edge[j];
      end else begin : g_bin_pipe
        assign bin_w = b_pipe[i-1][j];
      end

      tpu_pe #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C),
        .SAT     (SAT)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .ld   (WrEn && (Crow == ROW_BITS'(i))),
        .ain  (ain_w),
        .bin  (bin_w),
        .cld  (Cin[j]),
        .aout (a_pipe[i][j]),
        .bout (b_pipe[i][j]),
        .acc  (acc[i][j])
      );
    end
  end

  // Operands leaving the far edges have no consumer.
  always_comb begin
    unused_edges = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      unused_edges = unused_edges ^ (^a_pipe[i][DIM-1]) ^ (^b_pipe[DIM-1][i]);
    end
  end

  // Combinational row readback; rows beyond DIM-1 read as zero.
  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++) begin
      if (Crow == ROW_BITS'(r)) begin
        for (int j = 0; j < DIM; j++) begin
          Cout[j] = acc[r][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_tpu_systolic_array.sv
// Directed bench for tpu_systolic_array: 2x2 wrap and saturating arrays, a
// 3x3 array for out-of-range rows and a 4x4 array for reset and identity runs.
module tb_tpu_systolic_array;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 2x2 wrap instance
  logic              d2_en, d2_wr;
  logic [0:0]        d2_crow;
  logic [1:0][7:0]   d2_a, d2_b;
  logic [1:0][15:0]  d2_cin, d2_cout;
  // 2x2 saturating instance
  logic              s2_en, s2_wr;
  logic [0:0]        s2_crow;
  logic [1:0][7:0]   s2_a, s2_b;
  logic [1:0][15:0]  s2_cin, s2_cout;
  // 3x3 wrap instance
  logic              d3_en, d3_wr;
  logic [1:0]        d3_crow;
  logic [2:0][7:0]   d3_a, d3_b;
  logic [2:0][15:0]  d3_cin, d3_cout;
  // 4x4 wrap instance
  logic              d4_en, d4_wr;
  logic [1:0]        d4_crow;
  logic [3:0][7:0]   d4_a, d4_b;
  logic [3:0][15:0]  d4_cin, d4_cout;

  int n_pass  = 0;
  int n_total = 0;

  tpu_systolic_array #(.BITS_AB(8), .BITS_C(16), .DIM(2), .SAT(0), .SKEW(1)) u_d2 (
    .clk(clk), .rst(rst), .en(d2_en), .WrEn(d2_wr), .Crow(d2_crow),
    .A(d2_a), .B(d2_b), .Cin(d2_cin), .Cout(d2_cout));

  tpu_systolic_array #(.BITS_AB(8), .BITS_C(16), .DIM(2), .SAT(1), .SKEW(1)) u_s2 (
    .clk(clk), .rst(rst), .en(s2_en), .WrEn(s2_wr), .Crow(s2_crow),
    .A(s2_a), .B(s2_b), .Cin(s2_cin), .Cout(s2_cout));

  tpu_systolic_array #(.BITS_AB(8), .BITS_C(16), .DIM(3), .SAT(0), .SKEW(1)) u_d3 (
    .clk(clk), .rst(rst), .en(d3_en), .WrEn(d3_wr), .Crow(d3_crow),
    .A(d3_a), .B(d3_b), .Cin(d3_cin), .Cout(d3_cout));

  tpu_systolic_array #(.BITS_AB(8), .BITS_C(16), .DIM(4), .SAT(0), .SKEW(1)) u_d4 (
    .clk(clk), .rst(rst), .en(d4_en), .WrEn(d4_wr), .Crow(d4_crow),
    .A(d4_a), .B(d4_b), .Cin(d4_cin), .Cout(d4_cout));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    d2_en = 0; d2_wr = 0; d2_crow = '0; d2_a = '0; d2_b = '0; d2_cin = '0;
    s2_en = 0; s2_wr = 0; s2_crow = '0; s2_a = '0; s2_b = '0; s2_cin = '0;
    d3_en = 0; d3_wr = 0; d3_crow = '0; d3_a = '0; d3_b = '0; d3_cin = '0;
    d4_en = 0; d4_wr = 0; d4_crow = '0; d4_a = '0; d4_b = '0; d4_cin = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One enabled step on both 2x2 arrays with the same vector.
  task automatic vec2(input int a0, input int a1, input int b0, input int b1);
    d2_a[0] = 8'(a0); d2_a[1] = 8'(a1); d2_b[0] = 8'(b0); d2_b[1] = 8'(b1);
    s2_a = d2_a; s2_b = d2_b;
    d2_en = 1'b1; s2_en = 1'b1;
    tick();
    d2_en = 1'b0; s2_en = 1'b0;
    d2_a = '0; d2_b = '0; s2_a = '0; s2_b = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    d2_en = 1; d2_wr = 1; d2_a = 16'h0305; d2_b = 16'h0709; d2_cin = {16'd11, 16'd22};
    s2_en = 1; s2_wr = 1; s2_a = 16'h0305; s2_b = 16'h0709; s2_cin = {16'd11, 16'd22};
    d3_en = 1; d3_wr = 1; d3_a = 24'h010203; d3_b = 24'h040506; d3_cin = {3{16'd7}};
    d4_en = 1; d4_wr = 1; d4_a = 32'h01020304; d4_b = 32'h05060708; d4_cin = {4{16'd9}};
    tick();
    tick();
    rst = 1'b0;
    idle_all();
    for (int r = 0; r < 2; r++) begin
      d2_crow = 1'(r); s2_crow = 1'(r);
      #1;
      n_total++;
      if (d2_cout !== '0) $display("FAIL reset_d2 row%0d: got %h expected 0", r, d2_cout);
      else n_pass++;
      n_total++;
      if (s2_cout !== '0) $display("FAIL reset_s2 row%0d: got %h expected 0", r, s2_cout);
      else n_pass++;
    end
    for (int r = 0; r < 3; r++) begin
      d3_crow = 2'(r);
      #1;
      n_total++;
      if (d3_cout !== '0) $display("FAIL reset_d3 row%0d: got %h expected 0", r, d3_cout);
      else n_pass++;
    end
    for (int r = 0; r < 4; r++) begin
      d4_crow = 2'(r);
      #1;
      n_total++;
      if (d4_cout !== '0) $display("FAIL reset_d4 row%0d: got %h expected 0", r, d4_cout);
      else n_pass++;
    end
  endtask

  task automatic test_product_2x2();
    int exp_c [2][2];
    exp_c[0][0] = 19; exp_c[0][1] = 22; exp_c[1][0] = 43; exp_c[1][1] = 50;
    do_reset();
    vec2(1, 3, 5, 6);
    vec2(2, 4, 7, 8);
    vec2(0, 0, 0, 0);
    vec2(0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      d2_crow = 1'(r);
      #1;
      for (int j = 0; j < 2; j++) begin
        n_total++;
        if (d2_cout[j] !== 16'(exp_c[r][j]))
          $display("FAIL product_2x2 r%0d c%0d: got %0d expected %0d", r, j, $signed(d2_cout[j]), exp_c[r][j]);
        else n_pass++;
      end
    end
  endtask

  // Three rounds of identical stimulus; expected (wrap, sat) for acc(0,0).
  task automatic test_saturation();
    int a_v [3];
    int b_v [3];
    int n_v [3];
    int exp_wrap [3];
    int exp_sat  [3];
    a_v[0] = 127;  b_v[0] = 127;  n_v[0] = 3; exp_wrap[0] = -17149; exp_sat[0] = 32767;
    a_v[1] = -128; b_v[1] = -128; n_v[1] = 1; exp_wrap[1] = 16384;  exp_sat[1] = 16384;
    a_v[2] = -128; b_v[2] = 127;  n_v[2] = 3; exp_wrap[2] = 16768;  exp_sat[2] = -32768;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      for (int k = 0; k < n_v[t]; k++) vec2(a_v[t], 0, b_v[t], 0);
      vec2(0, 0, 0, 0);
      vec2(0, 0, 0, 0);
      d2_crow = 1'b0; s2_crow = 1'b0;
      #1;
      n_total++;
      if (d2_cout[0] !== 16'(exp_wrap[t]))
        $display("FAIL wrap_acc case%0d: got %0d expected %0d", t, $signed(d2_cout[0]), exp_wrap[t]);
      else n_pass++;
      n_total++;
      if (s2_cout[0] !== 16'(exp_sat[t]))
        $display("FAIL sat_acc case%0d: got %0d expected %0d", t, $signed(s2_cout[0]), exp_sat[t]);
      else n_pass++;
      n_total++;
      if (s2_cout[1] !== 16'd0)
        $display("FAIL sat_neighbour case%0d: got %0d expected 0", t, $signed(s2_cout[1]));
      else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    d2_wr = 1; d2_crow = 1'b1; d2_cin[0] = 16'(100); d2_cin[1] = 16'(-5);
    tick();
    d2_wr = 0;
    d2_crow = 1'b1; #1;
    n_total++;
    if (d2_cout !== {16'(-5), 16'(100)})
      $display("FAIL load_row1: got %0d,%0d expected 100,-5", $signed(d2_cout[0]), $signed(d2_cout[1]));
    else n_pass++;
    d2_crow = 1'b0; #1;
    n_total++;
    if (d2_cout !== '0) $display("FAIL load_row0_untouched: got %h expected 0", d2_cout);
    else n_pass++;
    // load and MAC in the same cycle: row 1 takes Cin, row 0 accumulates
    d2_en = 1; d2_wr = 1; d2_crow = 1'b1;
    d2_a[0] = 8'd1; d2_a[1] = 8'd1; d2_b[0] = 8'd2; d2_b[1] = 8'd2;
    d2_cin[0] = 16'(7); d2_cin[1] = 16'(-9);
    tick();
    d2_en = 0; d2_wr = 0; d2_a = '0; d2_b = '0; d2_cin = '0;
    d2_crow = 1'b1; #1;
    n_total++;
    if (d2_cout !== {16'(-9), 16'(7)})
      $display("FAIL load_wins_row1: got %0d,%0d expected 7,-9", $signed(d2_cout[0]), $signed(d2_cout[1]));
    else n_pass++;
    d2_crow = 1'b0; #1;
    n_total++;
    if (d2_cout !== {16'(0), 16'(2)})
      $display("FAIL mac_row0: got %0d,%0d expected 2,0", $signed(d2_cout[0]), $signed(d2_cout[1]));
    else n_pass++;
    // drain the operands shifted in during the load cycle
    d2_en = 1;
    tick();
    tick();
    d2_en = 0;
    d2_crow = 1'b0; #1;
    n_total++;
    if (d2_cout !== {16'(2), 16'(2)})
      $display("FAIL drain_row0: got %0d,%0d expected 2,2", $signed(d2_cout[0]), $signed(d2_cout[1]));
    else n_pass++;
    d2_crow = 1'b1; #1;
    n_total++;
    if (d2_cout !== {16'(-7), 16'(9)})
      $display("FAIL drain_row1: got %0d,%0d expected 9,-7", $signed(d2_cout[0]), $signed(d2_cout[1]));
    else n_pass++;
  endtask

  // Stall cycle with garbage on the inputs; nothing may change.
  task automatic stall_garbage();
    d2_en = 0; d2_wr = 0;
    d2_a[0] = 8'd9; d2_a[1] = 8'd9; d2_b[0] = 8'(-3); d2_b[1] = 8'd4;
    tick();
    d2_a = '0; d2_b = '0;
  endtask

  task automatic test_stall();
    int exp_c [2][2];
    do_reset();
    vec2(1, 3, 5, 6);
    stall_garbage();
    vec2(2, 4, 7, 8);
    stall_garbage();
    stall_garbage();
    // after two enabled cycles: PE00 = 19, PE01 = 6, PE10 = 15, PE11 = 0
    exp_c[0][0] = 19; exp_c[0][1] = 6; exp_c[1][0] = 15; exp_c[1][1] = 0;
    for (int r = 0; r < 2; r++) begin
      d2_crow = 1'(r);
      #1;
      for (int j = 0; j < 2; j++) begin
        n_total++;
        if (d2_cout[j] !== 16'(exp_c[r][j]))
          $display("FAIL stall_partial r%0d c%0d: got %0d expected %0d", r, j, $signed(d2_cout[j]), exp_c[r][j]);
        else n_pass++;
      end
    end
    vec2(0, 0, 0, 0);
    stall_garbage();
    vec2(0, 0, 0, 0);
    stall_garbage();
    exp_c[0][0] = 19; exp_c[0][1] = 22; exp_c[1][0] = 43; exp_c[1][1] = 50;
    for (int r = 0; r < 2; r++) begin
      d2_crow = 1'(r);
      #1;
      for (int j = 0; j < 2; j++) begin
        n_total++;
        if (d2_cout[j] !== 16'(exp_c[r][j]))
          $display("FAIL stall_final r%0d c%0d: got %0d expected %0d", r, j, $signed(d2_cout[j]), exp_c[r][j]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_crow_range();
    do_reset();
    d3_wr = 1; d3_crow = 2'd3; d3_cin = {3{16'd5}};
    tick();
    d3_crow = 2'd2; d3_cin[0] = 16'd1; d3_cin[1] = 16'd2; d3_cin[2] = 16'd3;
    tick();
    d3_wr = 0; d3_cin = '0;
    d3_crow = 2'd3; #1;
    n_total++;
    if (d3_cout !== '0) $display("FAIL crow_oob_read: got %h expected 0", d3_cout);
    else n_pass++;
    for (int r = 0; r < 2; r++) begin
      d3_crow = 2'(r); #1;
      n_total++;
      if (d3_cout !== '0) $display("FAIL crow_oob_ignored row%0d: got %h expected 0", r, d3_cout);
      else n_pass++;
    end
    d3_crow = 2'd2; #1;
    n_total++;
    if (d3_cout !== {16'd3, 16'd2, 16'd1})
      $display("FAIL crow_row2_load: got %h expected 000300020001", d3_cout);
    else n_pass++;
  endtask

  task automatic test_mid_reset_identity();
    int bm [4][4];
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        bm[k][j] = k * 4 + j - 5;
    do_reset();
    d4_a = 32'h01020304; d4_b = 32'h05060708; d4_en = 1;
    tick(); tick(); tick();
    d4_en = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d4_a = '0; d4_b = '0;
    for (int r = 0; r < 4; r++) begin
      d4_crow = 2'(r); #1;
      n_total++;
      if (d4_cout !== '0) $display("FAIL mid_reset row%0d: got %h expected 0", r, d4_cout);
      else n_pass++;
    end
    // identity x B
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        d4_a[i] = (i == k) ? 8'd1 : 8'd0;
        d4_b[i] = 8'(bm[k][i]);
      end
      d4_en = 1;
      tick();
    end
    d4_a = '0; d4_b = '0;
    for (int z = 0; z < 6; z++) tick();
    d4_en = 0;
    for (int r = 0; r < 4; r++) begin
      d4_crow = 2'(r); #1;
      for (int j = 0; j < 4; j++) begin
        n_total++;
        if (d4_cout[j] !== 16'(bm[r][j]))
          $display("FAIL identity r%0d c%0d: got %0d expected %0d", r, j, $signed(d4_cout[j]), bm[r][j]);
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
    test_reset();
    test_product_2x2();
    test_saturation();
    test_load_priority();
    test_stall();
    test_crow_range();
    test_mid_reset_identity();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
